// File: rtl/serdes_host_pkg.sv
`default_nettype none
// ============================================================================
// serdes_host_pkg
// Shared types and constants for the serdes_host byte-serial driver.
//   state_t      : controller state encoding
//   BYTE_W       : width of the chip-side byte bus
//   rsp_latency  : cycles from the accept edge to the first rsp_valid cycle
// Revision: 1.0 - initial release
// ============================================================================
package serdes_host_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Accept edge closes cycle 0; LOAD takes 2N, WAIT takes W, READ takes N+1,
  // so rsp_valid first appears in cycle 3N+W+2.
  function automatic int rsp_latency(input int nbytes, input int calc_wait);
    return 3 * nbytes + calc_wait + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_host_piso.sv
`default_nettype none
// ============================================================================
// byte_piso
// Parallel-load register that presents one byte per cycle, LSB byte first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din and present its byte 0 next cycle
//   shift      : present the next byte
//   clear      : drive the output byte to zero
//   din        : parallel data (NBYTES bytes)
//   dout       : registered output byte
// Priority: load > shift > clear; with none asserted the output holds.
// Revision: 1.0 - initial release
// ============================================================================
module byte_piso
  import serdes_host_pkg::*;
#(
  parameter int NBYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       shift,
  input  logic                       clear,
  input  logic [NBYTES*BYTE_W-1:0]   din,
  output logic [BYTE_W-1:0]          dout
);

  localparam int W = NBYTES * BYTE_W;

  // Holds the bytes not yet presented; byte 0 goes straight to dout on load.
  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      dout <= '0;
    end else if (load) begin
      dout <= din[BYTE_W-1:0];
      sr   <= din >> BYTE_W;
    end else if (shift) begin
      dout <= sr[BYTE_W-1:0];
      sr   <= sr >> BYTE_W;
    end else if (clear) begin
      dout <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serdes_host.sv
`default_nettype none
// ============================================================================
// serdes_host
// Host-side driver for the byte-serial operand/result port of the adder
// harness. Serializes an accepted operand pair onto bus_out with start_calc,
// waits CALC_WAIT cycles, strobes output_result and collects the returned
// bytes plus the overflow bit into a held response.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/ready/a/b     : operand request handshake
//   rsp_valid/ready         : response handshake
//   rsp_result, rsp_carry   : deserialized sum and overflow bit
//   bus_out, start_calc     : operand byte bus and load strobe to the chip
//   output_result           : result read strobe to the chip
//   bus_in, carry_in        : result byte bus and overflow pin from the chip
// Revision: 1.0 - initial release
// ============================================================================
module serdes_host
  import serdes_host_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CALC_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic [BYTE_W-1:0]  bus_out,
  output logic               start_calc,
  output logic               output_result,
  input  logic [BYTE_W-1:0]  bus_in,
  input  logic               carry_in
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int CNT_W  = $clog2(2 * NBYTES + 1);
  localparam int WAIT_W = (CALC_WAIT < 1) ? 1 : $clog2(CALC_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LOAD_LAST     = CNT_W'(2 * NBYTES);
  localparam logic [CNT_W-1:0]  READ_STB_LAST = CNT_W'(NBYTES);
  localparam logic [CNT_W-1:0]  READ_LAST     = CNT_W'(NBYTES + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE      = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(CALC_WAIT);

  if ((WIDTH % BYTE_W) != 0 || WIDTH < BYTE_W) begin : g_width_check
    $error("serdes_host: WIDTH must be a non-zero multiple of 8");
  end

  state_t              state;
  logic [CNT_W-1:0]    cnt;    // byte counter, restarted at 1 for each phase
  logic [WAIT_W-1:0]   wcnt;
  logic [WIDTH-1:0]    result_shifted;
  logic                accept;
  logic                load_last;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_ready && req_valid;
  assign load_last = (cnt == LOAD_LAST);

  // Returned bytes arrive LSB first: each new byte enters at the top and
  // after NBYTES captures byte 0 has walked down to bits [7:0].
  if (NBYTES == 1) begin : g_single_byte
    assign result_shifted = bus_in;
  end else begin : g_multi_byte
    assign result_shifted = {bus_in, rsp_result[WIDTH-1:BYTE_W]};
  end

  byte_piso #(
    .NBYTES (2 * NBYTES)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift ((state == ST_LOAD) && !load_last),
    .clear ((state == ST_LOAD) && load_last),
    .din   ({req_b, req_a}),
    .dout  (bus_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      wcnt          <= '0;
      start_calc    <= 1'b0;
      output_result <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_carry     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state      <= ST_LOAD;
            cnt        <= CNT_ONE;
            start_calc <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (load_last) begin
            start_calc <= 1'b0;
            if (CALC_WAIT == 0) begin
              state         <= ST_READ;
              cnt           <= CNT_ONE;
              output_result <= 1'b1;
            end else begin
              state <= ST_WAIT;
              wcnt  <= WAIT_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT: begin
          if (wcnt == WAIT_LAST) begin
            state         <= ST_READ;
            cnt           <= CNT_ONE;
            output_result <= 1'b1;
          end else begin
            wcnt <= wcnt + WAIT_ONE;
          end
        end

        ST_READ: begin
          // The chip answers one cycle after each strobe, so the first READ
          // cycle carries no data.
          if (cnt != CNT_ONE) begin
            rsp_result <= result_shifted;
          end
          if (cnt == READ_STB_LAST) begin
            output_result <= 1'b0;
          end
          if (cnt == READ_LAST) begin
            rsp_carry <= carry_in;
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serdes_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_serdes_host
// Self-checking bench for serdes_host: default configuration (WIDTH=32,
// CALC_WAIT=2) plus a WIDTH=16, CALC_WAIT=0 instance. Expected responses are
// queued at accept time and popped when rsp_valid is observed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serdes_host;
  import serdes_host_pkg::*;

  localparam int N1        = 4;
  localparam int W1        = 2;
  localparam int LAT1      = rsp_latency(N1, W1);
  localparam int LOAD_END1 = 2 * N1;
  localparam int RD_FIRST1 = 2 * N1 + W1 + 1;

  localparam int N2        = 2;
  localparam int LAT2      = rsp_latency(N2, 0);
  localparam int LOAD_END2 = 2 * N2;
  localparam int RD_FIRST2 = 2 * N2 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic [7:0]  bus_out, bus_in = '0;
  logic        start_calc, output_result, carry_in = 1'b0;

  logic        req_valid2 = 1'b0, req_ready2;
  logic [15:0] req_a2 = '0, req_b2 = '0;
  logic        rsp_valid2, rsp_ready2 = 1'b0;
  logic [15:0] rsp_result2;
  logic        rsp_carry2;
  logic [7:0]  bus_out2, bus_in2 = '0;
  logic        start_calc2, output_result2, carry_in2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  serdes_host u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .bus_out(bus_out), .start_calc(start_calc), .output_result(output_result),
    .bus_in(bus_in), .carry_in(carry_in)
  );

  serdes_host #(.WIDTH(16), .CALC_WAIT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_result(rsp_result2), .rsp_carry(rsp_carry2),
    .bus_out(bus_out2), .start_calc(start_calc2), .output_result(output_result2),
    .bus_in(bus_in2), .carry_in(carry_in2)
  );

  // Accepts one pair on the default DUT, checks the strobe/bus waveform for
  // every cycle up to the response and compares the response against the
  // scoreboard. Leaves the bench at the negedge of the rsp_valid cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input int carry_cyc, input string name);
    logic [63:0] ops;
    logic [32:0] sum;
    logic [32:0] exp_rsp;
    logic [11:0] exp_vec, got_vec;
    logic [7:0]  ob;
    ops = {b, a};
    sum = {1'b0, a} + {1'b0, b};
    @(posedge clk); #1;
    req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: req_ready=%b expected 1", name, req_ready);
    end
    sb.push_back({sum[32] && (carry_cyc == LAT1 - 1), sum[31:0]});
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = ~a; req_b = ~b;
    for (int k = 1; k < LAT1; k++) begin
      if (k > RD_FIRST1 && k <= RD_FIRST1 + N1) bus_in = sum[8*(k-RD_FIRST1-1) +: 8];
      else bus_in = 8'hA5;
      carry_in = (k == carry_cyc) ? sum[32] : 1'b0;
      @(negedge clk);
      if (k <= LOAD_END1) ob = ops[8*(k-1) +: 8];
      else ob = 8'h00;
      exp_vec = {(k <= LOAD_END1), ob, (k >= RD_FIRST1 && k < RD_FIRST1 + N1), 1'b0, 1'b0};
      got_vec = {start_calc, bus_out, output_result, rsp_valid, req_ready};
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s wave cycle %0d: {start,bus,oresult,rvalid,rready}=%h expected %h",
                 name, k, got_vec, exp_vec);
      end
      @(posedge clk); #1;
    end
    bus_in = 8'hA5; carry_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rsp_valid at cycle %0d: got %b expected 1", name, LAT1, rsp_valid);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: response with empty queue", name);
    end else begin
      exp_rsp = sb.pop_front();
      n_checks++;
      if ({rsp_carry, rsp_result} !== exp_rsp) begin
        n_fail++;
        $display("FAIL %s response: carry/result=%h expected %h", name,
                 {rsp_carry, rsp_result}, exp_rsp);
      end
    end
  endtask

  // Completes the DONE handshake and checks the return to IDLE.
  task automatic release_rsp(input string name);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, start_calc} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s release: {req_ready,rsp_valid,start_calc}=%b expected 100",
               name, {req_ready, rsp_valid, start_calc});
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, start_calc, output_result, bus_out, rsp_result, rsp_carry}
        !== {1'b1, 3'b000, 8'h00, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: ready=%b valid=%b start=%b ores=%b bus=%h res=%h carry=%b",
               req_ready, rsp_valid, start_calc, output_result, bus_out, rsp_result, rsp_carry);
    end
    n_checks++;
    if ({req_ready2, rsp_valid2, start_calc2, output_result2, bus_out2, rsp_result2, rsp_carry2}
        !== {1'b1, 3'b000, 8'h00, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_w16: ready=%b valid=%b start=%b ores=%b bus=%h res=%h",
               req_ready2, rsp_valid2, start_calc2, output_result2, bus_out2, rsp_result2);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, start_calc, output_result, bus_out} !== {1'b1, 3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_release: ready/valid/start/ores/bus=%h expected 800",
               {req_ready, rsp_valid, start_calc, output_result, bus_out});
    end
  endtask

  task automatic test_basic();
    run_txn(32'h04030201, 32'h08070605, 0, "basic");
    release_rsp("basic");
  endtask

  task automatic test_overflow();
    run_txn(32'h80000000, 32'h80000000, LAT1 - 1, "overflow");
    release_rsp("overflow");
    run_txn(32'h80000000, 32'h80000000, LAT1 - 2, "carry_early");
    release_rsp("carry_early");
    run_txn(32'hFFFFFFFF, 32'h00000001, LAT1 - 1, "carry_ripple");
    release_rsp("carry_ripple");
  endtask

  task automatic test_back_to_back();
    logic [32:0] held;
    run_txn(32'h1234ABCD, 32'h0F0F1111, 0, "backpressure");
    held = {1'b0, 32'h1234ABCD + 32'h0F0F1111};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = ~req_valid;
      req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, start_calc, output_result, bus_out, rsp_carry, rsp_result}
          !== {4'b1000, 8'h00, held}) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: valid=%b ready=%b start=%b bus=%h res=%h carry=%b",
                 i, rsp_valid, req_ready, start_calc, bus_out, rsp_result, rsp_carry);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, start_calc} !== 3'b100) begin
      n_fail++;
      $display("FAIL handshake_no_accept: {req_ready,rsp_valid,start_calc}=%b expected 100",
               {req_ready, rsp_valid, start_calc});
    end
    req_valid = 1'b0;
    run_txn(32'h00000010, 32'h00000020, 0, "after_backpressure");
    release_rsp("after_backpressure");
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    req_a = 32'h04030201; req_b = 32'h08070605; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({start_calc, bus_out} !== {1'b1, 8'h05}) begin
      n_fail++;
      $display("FAIL midload_pre: {start,bus}=%h expected 105", {start_calc, bus_out});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({start_calc, bus_out, output_result, rsp_valid, req_ready} !== {1'b0, 8'h00, 3'b001}) begin
      n_fail++;
      $display("FAIL midload_async: {start,bus,ores,valid,ready}=%h expected 001",
               {start_calc, bus_out, output_result, rsp_valid, req_ready});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h04030201, 32'h08070605, 0, "after_reset");
    release_rsp("after_reset");
  endtask

  task automatic test_calc_wait0();
    logic [15:0] a, b;
    logic [16:0] sum;
    logic [31:0] ops;
    logic [32:0] exp_rsp;
    logic [11:0] exp_vec, got_vec;
    logic [7:0]  ob;
    a = 16'h0201; b = 16'h04FF;
    sum = {1'b0, a} + {1'b0, b};
    ops = {b, a};
    @(posedge clk); #1;
    req_a2 = a; req_b2 = b; req_valid2 = 1'b1;
    sb.push_back({sum[16], 16'h0, sum[15:0]});
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    for (int k = 1; k < LAT2; k++) begin
      if (k > RD_FIRST2 && k <= RD_FIRST2 + N2) bus_in2 = sum[8*(k-RD_FIRST2-1) +: 8];
      else bus_in2 = 8'h5A;
      carry_in2 = (k == LAT2 - 1) ? sum[16] : 1'b0;
      @(negedge clk);
      if (k <= LOAD_END2) ob = ops[8*(k-1) +: 8];
      else ob = 8'h00;
      exp_vec = {(k <= LOAD_END2), ob, (k >= RD_FIRST2 && k < RD_FIRST2 + N2), 1'b0, 1'b0};
      got_vec = {start_calc2, bus_out2, output_result2, rsp_valid2, req_ready2};
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL w16 wave cycle %0d: {start,bus,oresult,rvalid,rready}=%h expected %h",
                 k, got_vec, exp_vec);
      end
      @(posedge clk); #1;
    end
    bus_in2 = 8'h5A; carry_in2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid2 !== 1'b1) begin
      n_fail++;
      $display("FAIL w16 rsp_valid at cycle %0d: got %b expected 1", LAT2, rsp_valid2);
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL w16 scoreboard: response with empty queue");
    end else begin
      exp_rsp = sb.pop_front();
      n_checks++;
      if ({rsp_carry2, 16'h0, rsp_result2} !== exp_rsp) begin
        n_fail++;
        $display("FAIL w16 response: carry/result=%h expected %h",
                 {rsp_carry2, 16'h0, rsp_result2}, exp_rsp);
      end
    end
    rsp_ready2 = 1'b1;
    @(posedge clk); #1;
    rsp_ready2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready2, rsp_valid2} !== 2'b10) begin
      n_fail++;
      $display("FAIL w16 release: {req_ready,rsp_valid}=%b expected 10", {req_ready2, rsp_valid2});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid_load();
    test_calc_wait0();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
